// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scan controller: horizontal FSM states,
// default 640x480@60 timing and the colour-bar palette ({b,g,r} byte order).
package vga_pkg;

    typedef enum logic [1:0] {
        ST_H_ACT   = 2'd0,
        ST_H_FRONT = 2'd1,
        ST_H_SYNC  = 2'd2,
        ST_H_BACK  = 2'd3
    } h_state_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam logic [23:0] BAR_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] BAR_YELLOW  = 24'h00_FF_FF;
    localparam logic [23:0] BAR_CYAN    = 24'hFF_FF_00;
    localparam logic [23:0] BAR_GREEN   = 24'h00_FF_00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] BAR_RED     = 24'h00_00_FF;
    localparam logic [23:0] BAR_BLUE    = 24'hFF_00_00;
    localparam logic [23:0] BAR_BLACK   = 24'h00_00_00;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        c = BAR_BLACK;
        unique case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            3'd7: c = BAR_BLACK;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipe with asynchronous active-low reset to zero.
// DEPTH of 0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster scan controller: timing FSM, pixel addressing, sync/blank alignment.
// Optional VGA_TESTPAT_EN adds iTESTPAT and an eight-bar colour test pattern.
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iEN,
`ifdef VGA_TESTPAT_EN
    input  logic              iTESTPAT,
`endif
    input  logic [23:0]       iPIX_BGR,
    output logic [ADDR_W-1:0] oADDR,
    output logic [11:0]       oX,
    output logic [11:0]       oY,
    output logic              oFRAME_START,
    output logic              oLINE_START,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [7:0]        b_data,
    output logic [7:0]        g_data,
    output logic [7:0]        r_data
);

    localparam logic [11:0] L_HA_LAST  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] L_HF_LAST  = 12'(H_FP - 1);
    localparam logic [11:0] L_HS_LAST  = 12'(H_SYNC - 1);
    localparam logic [11:0] L_HB_LAST  = 12'(H_BP - 1);
    localparam logic [11:0] L_V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] L_VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] L_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] L_V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    h_state_t          r_state, w_nstate;
    logic [11:0]       r_seg, w_nseg, r_v, w_nv, w_seg_last;
    logic              r_run, w_nrun, w_nact;
    logic              w_raw_act, w_raw_hs, w_raw_vs;
    logic [ADDR_W-1:0] r_addr;
    logic [11:0]       r_x, r_y;
    logic              r_fs, r_ls;
    logic [2:0]        w_dly;
    logic              r_hs_q, r_vs_q, r_blank_q;
    logic [23:0]       r_bgr, w_src;

    // r_run is the first-pixel flag: the first enabled edge only arms it, so the
    // held (0,0) position becomes the first displayed pixel on the following cycle.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= ST_H_ACT;
            r_seg   <= '0;
            r_v     <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_seg   <= w_nseg;
            r_v     <= w_nv;
            r_run   <= w_nrun;
        end
    end

    always_comb begin
        w_nstate   = r_state;
        w_nseg     = r_seg;
        w_nv       = r_v;
        w_nrun     = 1'b1;
        w_seg_last = L_HA_LAST;
        unique case (r_state)
            ST_H_ACT:   w_seg_last = L_HA_LAST;
            ST_H_FRONT: w_seg_last = L_HF_LAST;
            ST_H_SYNC:  w_seg_last = L_HS_LAST;
            ST_H_BACK:  w_seg_last = L_HB_LAST;
            default:    w_seg_last = L_HA_LAST;
        endcase
        if (!iEN) begin
            w_nstate = ST_H_ACT;
            w_nseg   = '0;
            w_nv     = '0;
            w_nrun   = 1'b0;
        end else if (r_run) begin
            if (r_seg == w_seg_last) begin
                w_nseg = '0;
                unique case (r_state)
                    ST_H_ACT:   w_nstate = ST_H_FRONT;
                    ST_H_FRONT: w_nstate = ST_H_SYNC;
                    ST_H_SYNC:  w_nstate = ST_H_BACK;
                    ST_H_BACK: begin
                        w_nstate = ST_H_ACT;
                        w_nv     = (r_v == L_V_LAST) ? '0 : r_v + 12'd1;
                    end
                    default:    w_nstate = ST_H_ACT;
                endcase
            end else begin
                w_nseg = r_seg + 12'd1;
            end
        end
    end

    always_comb begin
        w_raw_act = iEN && r_run && (r_state == ST_H_ACT) && (r_v < L_V_ACT);
        w_raw_hs  = iEN && r_run && (r_state == ST_H_SYNC);
        w_raw_vs  = iEN && r_run && (r_v >= L_VS_START) && (r_v < L_VS_END);
        w_nact    = w_nrun && (w_nstate == ST_H_ACT) && (w_nv < L_V_ACT);
    end

    // Position outputs are loaded from the next-state values so they line up
    // with the raw signals decoded from the current state.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_addr <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_fs   <= 1'b0;
            r_ls   <= 1'b0;
        end else begin
            r_fs <= w_nact && (w_nseg == '0) && (w_nv == '0);
            r_ls <= w_nact && (w_nseg == '0);
            if (w_nact) begin
                r_x    <= w_nseg;
                r_y    <= w_nv;
                r_addr <= ((w_nseg == '0) && (w_nv == '0)) ? '0 : r_addr + 1'b1;
            end
        end
    end

    vga_delay_line #(
        .DEPTH(PIPE_LAT),
        .WIDTH(3)
    ) u_sync_dly (
        .i_clk  (iVGA_CLK),
        .i_rst_n(iRST_n),
        .i_d    ({w_raw_hs, w_raw_vs, w_raw_act}),
        .o_q    (w_dly)
    );

`ifdef VGA_TESTPAT_EN
    logic [14:0] w_bar_prod;
    logic [2:0]  w_bar_idx, w_bar_dly;

    assign w_bar_prod = {r_x, 3'b000};
    assign w_bar_idx  = 3'(w_bar_prod / 15'(H_ACTIVE));

    vga_delay_line #(
        .DEPTH(PIPE_LAT),
        .WIDTH(3)
    ) u_bar_dly (
        .i_clk  (iVGA_CLK),
        .i_rst_n(iRST_n),
        .i_d    (w_bar_idx),
        .o_q    (w_bar_dly)
    );

    assign w_src = iTESTPAT ? bar_colour(w_bar_dly) : iPIX_BGR;
`else
    assign w_src = iPIX_BGR;
`endif

    // Final stage: the delay line supplies PIPE_LAT cycles, this register the +1,
    // so colour and blank leave together and colour is gated by its own blank.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_hs_q    <= 1'b0;
            r_vs_q    <= 1'b0;
            r_blank_q <= 1'b0;
            r_bgr     <= '0;
        end else begin
            r_hs_q    <= w_dly[2];
            r_vs_q    <= w_dly[1];
            r_blank_q <= w_dly[0];
            r_bgr     <= w_dly[0] ? w_src : '0;
        end
    end

    assign oADDR        = r_addr;
    assign oX           = r_x;
    assign oY           = r_y;
    assign oFRAME_START = r_fs;
    assign oLINE_START  = r_ls;
    assign oHS          = r_hs_q ^ ~HS_POL;
    assign oVS          = r_vs_q ^ ~VS_POL;
    assign oBLANK_n     = r_blank_q;
    assign b_data       = r_bgr[23:16];
    assign g_data       = r_bgr[15:8];
    assign r_data       = r_bgr[7:0];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller on an 8x4 visible raster (16x8 total).
module tb_vga_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        testpat;
    logic [23:0] pix;
    logic [18:0] oADDR;
    logic [11:0] oX, oY;
    logic        oFRAME_START, oLINE_START, oHS, oVS, oBLANK_n;
    logic [7:0]  b_data, g_data, r_data;

    int n_vec    = 0;
    int n_miscmp = 0;

    initial forever #5 clk = ~clk;

    vga_scan_controller #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(2), .ADDR_W(19)
    ) dut (
        .iVGA_CLK    (clk),
        .iRST_n      (rst_n),
        .iEN         (en),
`ifdef VGA_TESTPAT_EN
        .iTESTPAT    (testpat),
`endif
        .iPIX_BGR    (pix),
        .oADDR       (oADDR),
        .oX          (oX),
        .oY          (oY),
        .oFRAME_START(oFRAME_START),
        .oLINE_START (oLINE_START),
        .oHS         (oHS),
        .oVS         (oVS),
        .oBLANK_n    (oBLANK_n),
        .b_data      (b_data),
        .g_data      (g_data),
        .r_data      (r_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix_of(input logic [18:0] a);
        return 24'h123456 ^ {3{a[7:0]}};
    endfunction

    // Reference raster, k = cycles since pixel (0,0): 16-cycle lines, 8-line frames.
    function automatic bit m_act(input int k);
        if (k < 0) return 1'b0;
        return ((k % 16) < 8) && (((k / 16) % 8) < 4);
    endfunction
    function automatic bit m_hs(input int k);
        if (k < 0) return 1'b0;
        return ((k % 16) >= 10) && ((k % 16) < 13);
    endfunction
    function automatic bit m_vs(input int k);
        if (k < 0) return 1'b0;
        return (((k / 16) % 8) >= 5) && (((k / 16) % 8) < 7);
    endfunction
    function automatic int m_x(input int k);
        if (((k / 16) % 8) >= 4 || (k % 16) >= 8) return 7;
        return k % 16;
    endfunction
    function automatic int m_y(input int k);
        if (((k / 16) % 8) >= 4) return 3;
        return (k / 16) % 8;
    endfunction
    function automatic int m_addr(input int k);
        return m_y(k) * 8 + m_x(k);
    endfunction

    // Pixel source answers each address PIPE_LAT (2) cycles after it was issued.
    logic [18:0] addr_hist [3];
    initial begin
        pix = '0;
        addr_hist[0] = '0;
        addr_hist[1] = '0;
        addr_hist[2] = '0;
        forever begin
            @(posedge clk);
            #1;
            addr_hist[2] = addr_hist[1];
            addr_hist[1] = addr_hist[0];
            addr_hist[0] = oADDR;
            pix = pix_of(addr_hist[2]);
        end
    end

    initial begin
        int   last_ls, last_fs, hs_fall, vs_low, max_addr;
        logic prev_hs;
        logic [23:0] exp_bgr;
        last_ls  = -100;
        last_fs  = -1;
        hs_fall  = 0;
        vs_low   = 0;
        max_addr = 0;
        prev_hs  = 1'b1;

        rst_n   = 1'b0;
        en      = 1'b1;
        testpat = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr",  oADDR, 0);
        chk("rst_blank", oBLANK_n, 0);
        chk("rst_hs",    oHS, 1);
        chk("rst_vs",    oVS, 1);
        chk("rst_bgr",   {b_data, g_data, r_data}, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 324; k++) begin
            @(negedge clk);
            if (k < 290) begin
                exp_bgr = m_act(k - 3) ? pix_of(19'(m_addr(k - 3))) : 24'h0;
                chk("addr",  oADDR, m_addr(k));
                chk("x",     oX, m_x(k));
                chk("y",     oY, m_y(k));
                chk("fstart", oFRAME_START, (k % 128) == 0);
                chk("lstart", oLINE_START, ((k % 16) == 0) && m_act(k));
                chk("blank", oBLANK_n, m_act(k - 3));
                chk("hs",    oHS, !m_hs(k - 3));
                chk("vs",    oVS, !m_vs(k - 3));
                chk("bgr",   {b_data, g_data, r_data}, exp_bgr);

                if (oLINE_START) begin
                    if (oY != 0 && last_ls >= 0) chk("line_period", k - last_ls, 16);
                    last_ls = k;
                end
                if (oFRAME_START) begin
                    if (last_fs >= 0) begin
                        chk("frame_period", k - last_fs, 128);
                        chk("addr_max", max_addr, 31);
                    end
                    last_fs  = k;
                    max_addr = 0;
                end
                if (int'(oADDR) > max_addr) max_addr = int'(oADDR);
                if (prev_hs && !oHS) begin
                    hs_fall = k;
                    if (k - last_ls < 16) chk("hs_offset", k - last_ls, 13);
                end
                if (!prev_hs && oHS) chk("hs_width", k - hs_fall, 3);
                prev_hs = oHS;
                if (k >= 3 && !oVS) vs_low++;
                if (k == 130 || k == 258) begin
                    chk("vs_low_frame", vs_low, 32);
                    vs_low = 0;
                end
            end

            if (k == 293) en = 1'b0;
            if (k == 295) chk("dis_blank_prev", oBLANK_n, 1);
            if (k == 296) chk("dis_blank_low", oBLANK_n, 0);
            if (k == 298) begin
                chk("dis_addr_hold", oADDR, 21);
                chk("dis_x_hold", oX, 5);
                chk("dis_y_hold", oY, 2);
                chk("dis_hs", oHS, 1);
            end
            if (k == 302) begin
                chk("dis_vs", oVS, 1);
                chk("dis_bgr", {b_data, g_data, r_data}, 0);
            end
            if (k == 303) en = 1'b1;
            if (k == 304) begin
                chk("re_fstart", oFRAME_START, 1);
                chk("re_addr", oADDR, 0);
                chk("re_x", oX, 0);
            end
            if (k == 306) chk("re_blank_pre", oBLANK_n, 0);
            if (k == 307) begin
                chk("re_blank", oBLANK_n, 1);
                chk("re_bgr", {b_data, g_data, r_data}, 24'h123456);
            end
            if (k == 323) begin
                chk("pre_rst_addr", oADDR, 11);
                chk("pre_rst_blank", oBLANK_n, 1);
                #2;
                rst_n = 1'b0;
                #1;
                chk("async_addr", oADDR, 0);
                chk("async_x", oX, 0);
                chk("async_y", oY, 0);
                chk("async_blank", oBLANK_n, 0);
                chk("async_hs", oHS, 1);
                chk("async_vs", oVS, 1);
                chk("async_bgr", {b_data, g_data, r_data}, 0);
            end
        end

        @(negedge clk);
        rst_n = 1'b1;
`ifdef VGA_TESTPAT_EN
        testpat = 1'b1;
`endif
        @(negedge clk);
        chk("rel_fstart", oFRAME_START, 1);
        chk("rel_addr", oADDR, 0);
`ifdef VGA_TESTPAT_EN
        for (int kk = 1; kk <= 10; kk++) begin
            @(negedge clk);
            if (kk == 3)  chk("bar_white", {b_data, g_data, r_data}, 24'hFFFFFF);
            if (kk == 4)  chk("bar_yellow", {b_data, g_data, r_data}, 24'h00FFFF);
            if (kk == 10) chk("bar_black", {b_data, g_data, r_data}, 24'h000000);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
